// File: rtl/calc_ctrl.sv
// calc_ctrl: command sequencer for the binary calculator.
// Tracks the operating mode from inputKey edges, accepts one command at a time
// and walks the ALU / memory / serial-transmit strobes in order.
//
// Ports:
//   clk, reset          - system clock, synchronous active-high reset
//   inputKey            - mode key, each rising edge advances mode (IDLE only)
//   validCmd            - level-sensitive command request
//   RW                  - mode-1 direction (1 = write, 0 = read)
//   ADDR                - command address
//   txDone              - end-of-frame pulse from the transceiver
//   mode                - current operating mode
//   calcBusy            - command in progress
//   aluEn, memEn, memRW - ALU latch / memory access strobes
//   memAddr             - address captured at acceptance
//   txLoad, txSel       - transceiver load strobe and source select
//   cmdDone, cmdErr     - completion / transmit-timeout pulses
module calc_ctrl #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned TX_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inputKey,
  input  logic                  validCmd,
  input  logic                  RW,
  input  logic [ADDR_WIDTH-1:0] ADDR,
  input  logic                  txDone,
  output logic [1:0]            mode,
  output logic                  calcBusy,
  output logic                  aluEn,
  output logic                  memEn,
  output logic                  memRW,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic                  txLoad,
  output logic                  txSel,
  output logic                  cmdDone,
  output logic                  cmdErr
);

  localparam int unsigned CNT_W = $clog2(TX_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TX_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALU,
    S_MEMWR,
    S_MEMRD,
    S_MEMWAIT,
    S_TXLOAD,
    S_TXWAIT
  } state_t;

  state_t           state;
  logic             key_prev;
  logic [1:0]       cmd_mode;
  logic [CNT_W-1:0] to_cnt;
  logic             key_edge;

  assign key_edge = inputKey & ~key_prev;

  // Strobes are written on the transition into the state that owns them, so
  // every output register mirrors the state register one-for-one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      key_prev <= 1'b0;
      mode     <= 2'd0;
      cmd_mode <= 2'd0;
      to_cnt   <= '0;
      memAddr  <= '0;
      calcBusy <= 1'b0;
      aluEn    <= 1'b0;
      memEn    <= 1'b0;
      memRW    <= 1'b0;
      txLoad   <= 1'b0;
      txSel    <= 1'b0;
      cmdDone  <= 1'b0;
      cmdErr   <= 1'b0;
    end else begin
      key_prev <= inputKey;
      aluEn    <= 1'b0;
      memEn    <= 1'b0;
      memRW    <= 1'b0;
      txLoad   <= 1'b0;
      cmdDone  <= 1'b0;
      cmdErr   <= 1'b0;

      case (state)
        S_IDLE: begin
          // Key edges are honoured only here; the command below still sees
          // the old mode because mode is a register.
          if (key_edge) begin
            mode <= mode + 2'd1;
          end
          if (validCmd && (mode != 2'd0)) begin
            memAddr  <= ADDR;
            cmd_mode <= mode;
            calcBusy <= 1'b1;
            if ((mode == 2'd1) && !RW) begin
              state <= S_MEMRD;
              memEn <= 1'b1;
            end else begin
              state <= S_ALU;
              aluEn <= 1'b1;
            end
          end
        end

        S_ALU: begin
          if (cmd_mode == 2'd2) begin
            state  <= S_TXLOAD;
            txLoad <= 1'b1;
            txSel  <= 1'b0;
          end else begin
            state <= S_MEMWR;
            memEn <= 1'b1;
            memRW <= 1'b1;
          end
        end

        S_MEMWR: begin
          // Mode 3 reads back what it just wrote; mode 1 write ends here.
          if (cmd_mode == 2'd3) begin
            state <= S_MEMRD;
            memEn <= 1'b1;
          end else begin
            state    <= S_IDLE;
            calcBusy <= 1'b0;
            cmdDone  <= 1'b1;
          end
        end

        S_MEMRD: begin
          state <= S_MEMWAIT;
        end

        // One-cycle memory read latency before the transceiver loads.
        S_MEMWAIT: begin
          state  <= S_TXLOAD;
          txLoad <= 1'b1;
          txSel  <= 1'b1;
        end

        S_TXLOAD: begin
          state  <= S_TXWAIT;
          to_cnt <= '0;
        end

        // txDone takes priority over a timeout landing in the same cycle.
        S_TXWAIT: begin
          if (txDone) begin
            state    <= S_IDLE;
            calcBusy <= 1'b0;
            txSel    <= 1'b0;
            cmdDone  <= 1'b1;
          end else if (to_cnt == CNT_LAST) begin
            state    <= S_IDLE;
            calcBusy <= 1'b0;
            txSel    <= 1'b0;
            cmdErr   <= 1'b1;
          end else begin
            to_cnt <= to_cnt + CNT_W'(1);
          end
        end

        default: begin
          state    <= S_IDLE;
          calcBusy <= 1'b0;
          txSel    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_ctrl.sv
// tb_calc_ctrl: directed and randomized checks of calc_ctrl against a
// phase-list reference model built from the command sequencing rules.
module tb_calc_ctrl;

  localparam int unsigned AW = 8;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          inputKey;
  logic          validCmd;
  logic          RW;
  logic [AW-1:0] ADDR;
  logic          txDone;
  logic [1:0]    mode;
  logic          calcBusy, aluEn, memEn, memRW, txLoad, txSel, cmdDone, cmdErr;
  logic [AW-1:0] memAddr;

  calc_ctrl #(.ADDR_WIDTH(AW), .TX_TIMEOUT(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .inputKey (inputKey),
    .validCmd (validCmd),
    .RW       (RW),
    .ADDR     (ADDR),
    .txDone   (txDone),
    .mode     (mode),
    .calcBusy (calcBusy),
    .aluEn    (aluEn),
    .memEn    (memEn),
    .memRW    (memRW),
    .memAddr  (memAddr),
    .txLoad   (txLoad),
    .txSel    (txSel),
    .cmdDone  (cmdDone),
    .cmdErr   (cmdErr)
  );

  always #5 clk = ~clk;

  typedef enum int {P_ALU, P_MWR, P_MRD, P_MWT, P_TXL, P_TXW} phase_t;

  int            checks = 0;
  int            errors = 0;
  logic [1:0]    mode_m = 2'd0;
  logic [AW-1:0] addr_m = '0;

  // Expected {busy, aluEn, memEn, memRW, txLoad, txSel, done, err} per phase.
  function automatic logic [7:0] strb(input phase_t p, input logic sel);
    case (p)
      P_ALU:   return 8'b1100_0000;
      P_MWR:   return 8'b1011_0000;
      P_MRD:   return 8'b1010_0000;
      P_MWT:   return 8'b1000_0000;
      P_TXL:   return {5'b10001, sel, 2'b00};
      default: return {5'b10000, sel, 2'b00};
    endcase
  endfunction

  task automatic check_outs(input string tag, input logic [7:0] exp_s);
    logic [7:0] got;
    got = {calcBusy, aluEn, memEn, memRW, txLoad, txSel, cmdDone, cmdErr};
    checks++;
    assert (got === exp_s) else begin
      errors++;
      $error("FAIL %s strobes got=%b exp=%b t=%0t", tag, got, exp_s, $time);
    end
    checks++;
    assert (mode === mode_m) else begin
      errors++;
      $error("FAIL %s mode got=%0d exp=%0d t=%0t", tag, mode, mode_m, $time);
    end
    checks++;
    assert (memAddr === addr_m) else begin
      errors++;
      $error("FAIL %s memAddr got=%0d exp=%0d t=%0t", tag, memAddr, addr_m, $time);
    end
  endtask

  task automatic press_key(input string tag);
    inputKey = 1'b1;
    @(posedge clk); #1;
    inputKey = 1'b0;
    mode_m = mode_m + 2'd1;
    check_outs(tag, 8'h00);
    @(posedge clk); #1;
    check_outs(tag, 8'h00);
  endtask

  task automatic set_mode(input logic [1:0] target);
    while (mode_m != target) press_key("set_mode");
  endtask

  // Entered in an IDLE cycle (#1 after the edge). d = cycles from txLoad to
  // txDone, 0 = never (timeout). hold keeps validCmd high into the next call.
  task automatic run_cmd(input string tag, input logic rw, input logic [AW-1:0] addr,
                         input int d, input bit hold, input bit key_acc, input bit key_mid);
    phase_t     seq[$];
    logic [1:0] m;
    logic       sel;
    bit         has_tx;
    int         t;
    int         n_wait;
    m = mode_m;
    sel = 1'b0;
    has_tx = 1'b1;
    t = 0;
    if (m == 2'd1 && rw) begin
      seq = '{P_ALU, P_MWR};
      has_tx = 1'b0;
    end else if (m == 2'd1) begin
      seq = '{P_MRD, P_MWT, P_TXL};
      sel = 1'b1;
    end else if (m == 2'd2) begin
      seq = '{P_ALU, P_TXL};
    end else begin
      seq = '{P_ALU, P_MWR, P_MRD, P_MWT, P_TXL};
      sel = 1'b1;
    end
    if (has_tx) begin
      t = seq.size();
      n_wait = (d > 0) ? d : int'(TO);
      for (int k = 0; k < n_wait; k++) seq.push_back(P_TXW);
    end

    ADDR = addr;
    RW = rw;
    validCmd = 1'b1;
    if (key_acc) inputKey = 1'b1;
    @(posedge clk); #1;
    addr_m = addr;
    if (key_acc) mode_m = mode_m + 2'd1;
    inputKey = 1'b0;
    if (!hold) begin
      validCmd = 1'b0;
      ADDR = AW'($urandom);
      RW = 1'($urandom);
    end

    for (int i = 1; i <= seq.size(); i++) begin
      check_outs(tag, strb(seq[i-1], sel));
      txDone = (has_tx && d > 0 && i == t + d);
      inputKey = (key_mid && i == 2);
      @(posedge clk); #1;
    end
    txDone = 1'b0;
    inputKey = 1'b0;
    check_outs(tag, (has_tx && d == 0) ? 8'b0000_0001 : 8'b0000_0010);
  endtask

  initial begin
    reset = 1'b1;
    inputKey = 1'b0;
    validCmd = 1'b0;
    RW = 1'b0;
    ADDR = '0;
    txDone = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check_outs("reset", 8'h00);
    reset = 1'b0;
    @(posedge clk); #1;
    check_outs("post_reset", 8'h00);

    // Four key edges walk 1, 2, 3 and wrap to 0.
    for (int i = 0; i < 4; i++) press_key("key_walk");

    // Mode 1 write to address 4.
    set_mode(2'd1);
    run_cmd("m1_write", 1'b1, 8'd4, 0, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_outs("m1_write_idle", 8'h00);

    // Mode 1 read, txDone 10 cycles after txLoad, key pressed mid-command.
    run_cmd("m1_read", 1'b0, 8'd4, 10, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_outs("m1_read_idle", 8'h00);

    // Mode 2 with no txDone: timeout, then a stray txDone in IDLE.
    set_mode(2'd2);
    run_cmd("m2_timeout", 1'b0, 8'd9, 0, 1'b0, 1'b0, 1'b0);
    txDone = 1'b1;
    @(posedge clk); #1;
    txDone = 1'b0;
    check_outs("stray_txdone", 8'h00);
    @(posedge clk); #1;
    check_outs("stray_txdone2", 8'h00);
    run_cmd("m2_after_err", 1'b1, 8'd33, 1, 1'b0, 1'b0, 1'b0);

    // Mode 3 back-to-back with validCmd held high.
    set_mode(2'd3);
    run_cmd("m3_hold_a", 1'b0, 8'd77, 3, 1'b1, 1'b0, 1'b0);
    run_cmd("m3_hold_b", 1'b0, 8'd77, 2, 1'b0, 1'b0, 1'b0);

    // Key edge in the acceptance cycle: command uses the old mode (3).
    @(posedge clk); #1;
    run_cmd("key_at_accept", 1'b1, 8'd200, 4, 1'b0, 1'b1, 1'b0);

    // Randomized commands.
    for (int n = 0; n < 30; n++) begin
      logic [1:0]    tgt;
      logic          rw;
      logic [AW-1:0] a;
      int            d;
      tgt = 2'($urandom_range(1, 3));
      set_mode(tgt);
      rw = 1'($urandom);
      a = AW'($urandom);
      d = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 12));
      run_cmd("rand", rw, a, d, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
      if (validCmd && mode_m != 2'd0) begin
        run_cmd("rand_tail", rw, a, int'($urandom_range(1, 6)), 1'b0, 1'b0, 1'b0);
      end
      validCmd = 1'b0;
      @(posedge clk); #1;
      check_outs("rand_idle", 8'h00);
    end

    // Reset in TXWAIT of a mode 2 command, with txDone in flight.
    set_mode(2'd2);
    ADDR = 8'd55;
    validCmd = 1'b1;
    @(posedge clk); #1;
    validCmd = 1'b0;
    addr_m = 8'd55;
    check_outs("rst_alu", 8'b1100_0000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    check_outs("rst_txwait", 8'b1000_0000);
    reset = 1'b1;
    txDone = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    txDone = 1'b0;
    mode_m = 2'd0;
    addr_m = '0;
    check_outs("rst_mid", 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_outs("rst_after", 8'h00);
    end

    // Mode 0 ignores commands.
    validCmd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_outs("mode0_cmd", 8'h00);
    end
    validCmd = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_ctrl.md
# calc_ctrl

Command sequencer for the binary calculator. Sits between the user-facing command inputs (`inputKey`, `validCmd`, `RW`, `ADDR`) and the shared datapath: ALU, result memory and serial transceiver. It tracks the operating mode, accepts one command at a time and issues the ALU, memory and transmit strobes in order. It drives `calcBusy` and reports completion or a transmit timeout.

## Interface
Parameters:
- `ADDR_WIDTH`, 8, memory address width
- `TX_TIMEOUT`, 1024, max cycles spent in TXWAIT before abort (≥2)

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `inputKey`  in  1  mode key; each rising edge advances mode
- `validCmd`  in  1  command request, level-sensitive
- `RW`  in  1  mode-1 direction: 1 = write, 0 = read
- `ADDR`  in  ADDR_WIDTH  command address
- `txDone`  in  1  one-cycle pulse from serial transceiver at end of frame
- `mode`  out  2  current mode
- `calcBusy`  out  1  command in progress
- `aluEn`  out  1  latch ALU result this cycle
- `memEn`  out  1  memory access this cycle
- `memRW`  out  1  1 = write, 0 = read; valid with `memEn`
- `memAddr`  out  ADDR_WIDTH  captured command address
- `txLoad`  out  1  load transceiver and start frame
- `txSel`  out  1  transceiver source: 0 = ALU result, 1 = memory read data
- `cmdDone`  out  1  one-cycle completion pulse
- `cmdErr`  out  1  one-cycle timeout pulse

## Operation
- Key edge detection: `keyPrev` register. Edge = `inputKey & ~keyPrev`. Mode increments by one per edge, wrapping 3→0. Edges are acted on only in IDLE; edges during a command are dropped, not queued.
- Modes:
  - 0 = idle: commands ignored.
  - 1 = memory: `RW` selects write or read.
  - 2 = direct transmit.
  - 3 = write then read-back.
- Acceptance: in IDLE with `validCmd=1` and `mode≠0`. At that edge, capture `ADDR`→`memAddr`, `RW`, and `mode`.
  - The command executes with the captured values.
  - `validCmd` held high re-issues the command after each completion. The FSM always spends at least one IDLE cycle between commands.
- States: IDLE, ALU, MEMWR, MEMRD, MEMWAIT, TXLOAD, TXWAIT.
- Sequences:
  - mode 1, RW=1: ALU→MEMWR→IDLE
  - mode 1, RW=0: MEMRD→MEMWAIT→TXLOAD(`txSel=1`)→TXWAIT→IDLE
  - mode 2: ALU→TXLOAD(`txSel=0`)→TXWAIT→IDLE
  - mode 3: ALU→MEMWR→MEMRD→MEMWAIT→TXLOAD(`txSel=1`)→TXWAIT→IDLE
- Strobes are Moore outputs decoded from the state register:
  - `aluEn` in ALU
  - `memEn` in MEMWR/MEMRD
  - `memRW=1` in MEMWR
  - `txLoad` in TXLOAD
- `txSel` is held from TXLOAD through TXWAIT. Memory read latency is 1 cycle, covered by MEMWAIT.
- TXWAIT:
  - Exit on `txDone`.
  - A timeout counter clears on entry and increments each cycle. If the count reaches `TX_TIMEOUT-1` with no `txDone`, go to IDLE and pulse `cmdErr` instead of `cmdDone`.
  - `txDone` and the timeout in the same cycle: `txDone` wins.
- `txDone` outside TXWAIT is ignored.
- `calcBusy` = state≠IDLE.

## Timing
- Reset values: state IDLE, `mode=0`, `keyPrev=0`, `memAddr=0`. All strobes, `txSel`, `calcBusy`, `cmdDone` and `cmdErr` are 0.
- Acceptance at edge k: first sequence state and `calcBusy=1` from cycle k+1.
- `cmdDone` and `cmdErr` are registered. They are high for exactly the first IDLE cycle after the command, with `calcBusy=0` that cycle.
- Latency from acceptance to first IDLE, with txDone arriving D cycles after TXLOAD:
  - mode 1 write: 3
  - mode 1 read: 4+D
  - mode 2: 3+D
  - mode 3: 6+D
- Key edge and acceptance in the same IDLE cycle: the command uses the old mode, and the new mode is visible next cycle.
- `reset` mid-command: at the next edge the FSM returns to IDLE and all outputs take reset values (mode→0). No `cmdDone`/`cmdErr` is issued, and any in-flight `txDone` is ignored.
- Timeout counter width is $clog2(TX_TIMEOUT). It never wraps, because it is cleared on TXWAIT entry.

## Test plan
- Reset, three `inputKey` rising edges: `mode` reads 1, 2, 3 one cycle after each edge. A fourth edge gives 0. All strobes stay 0.
- Mode 1, `RW=1`, `ADDR=4`, `validCmd` one cycle: `aluEn` one cycle, then `memEn=1`, `memRW=1`, `memAddr=4` one cycle. `cmdDone` 3 cycles after acceptance, `calcBusy` high exactly 2 cycles.
- Mode 1, `RW=0`, `ADDR=4`, `txDone` 10 cycles after `txLoad`: sequence is `memEn` read → wait → `txLoad` with `txSel=1`. `cmdDone` 14 cycles after acceptance. A key edge pressed mid-command leaves `mode` unchanged.
- Mode 2, `txDone` never asserted, `TX_TIMEOUT=16`: `cmdErr` one cycle, no `cmdDone`. Next command accepted normally. A stray `txDone` pulse in IDLE has no effect.
- Mode 3 with `validCmd` held high: ALU, MEMWR, MEMRD, MEMWAIT, TXLOAD, TXWAIT order per command. One IDLE cycle with `cmdDone` between back-to-back commands.
- Mode 2 command, `reset` asserted in TXWAIT: next cycle IDLE, `mode=0`, all outputs 0, no `cmdDone`. Mode-0 `validCmd` afterwards: `calcBusy` stays 0.
